instruction_fetch: RTL

Fetch stage directly upstream of the instruction decoder / control unit.
- Holds the PC and issues one request at a time to instruction memory over a req/gnt + rvalid handshake.
- Presents the returned word as instr_code together with its PC and PC+4.
- Selects the next PC from the 2-bit PCSrc encoding (0 PC+4, 1 branch, 2 JAL, 3 JALR) that the decode/execute side returns when it accepts the instruction.
- Supports an asynchronous-to-pipeline flush (trap/restart).

---
 rtl/instruction_fetch.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly upstream of the decoder / control unit.
// It holds the PC and keeps at most one request outstanding to instruction
// memory (req/gnt address phase, rvalid data phase). The returned word is
// registered and presented as instr_code together with its PC and PC+4. When
// the consumer accepts the instruction, the next PC is taken from the
// decode/execute side's pc_src select. A flush restarts fetch at flush_pc and
// discards whatever is in flight or held. A selected next PC with bit 1 set
// stops fetch permanently (misaligned_err) until reset.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned address (addr = pc)
//   imem_gnt          memory accepts the request this cycle
//   imem_rvalid/rdata response for the granted request
//   instr_valid       instr_code / instr_pc / instr_pc_plus4 valid
//   instr_ready       consumer accepts the instruction
//   instr_code        fetched instruction word (NOP after reset)
//   instr_pc          PC of instr_code
//   instr_pc_plus4    instr_pc + 4, link value for JAL/JALR
//   pc_src            next-PC select: 0 PC+4, 1 branch, 2 JAL, 3 JALR
//   branch_target     next PC when pc_src = 1
//   jal_target        next PC when pc_src = 2
//   jalr_target       next PC when pc_src = 3 (bit 0 cleared)
//   flush, flush_pc   restart fetch at flush_pc (bits [1:0] cleared)
//   misaligned_err    sticky: selected next PC had bit 1 set, fetch halted
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        misaligned_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic        capture_pc;    // request granted: remember the issued PC
  logic        capture_code;  // live response: register the instruction word
  logic        set_err;       // accepted instruction selected a misaligned PC
  logic [31:0] next_pc;
  logic [31:0] flush_pc_aligned;

  assign instr_pc_plus4   = instr_pc + 32'd4;
  assign flush_pc_aligned = {flush_pc[31:2], 2'b00};

  // Next PC for the accepted instruction; only meaningful on a handshake.
  always_comb begin
    unique case (pc_src)
      2'd0:    next_pc = instr_pc_plus4;
      2'd1:    next_pc = branch_target;
      2'd2:    next_pc = jal_target;
      default: next_pc = {jalr_target[31:1], 1'b0};
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Flush outranks every other event in REQ/WAIT/HOLD; BOOT
  // and HALT ignore it.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    discard_nxt  = discard;
    capture_pc   = 1'b0;
    capture_code = 1'b0;
    set_err      = 1'b0;
    unique case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        if (flush) begin
          pc_nxt = flush_pc_aligned;
          if (imem_gnt) begin
            // The old request was accepted anyway; its response must be eaten.
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end
        end else if (imem_gnt) begin
          state_nxt  = S_WAIT;
          capture_pc = 1'b1;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_nxt = flush_pc_aligned;
          if (imem_rvalid) begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end else begin
            state_nxt    = S_HOLD;
            capture_code = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_nxt    = flush_pc_aligned;
          state_nxt = S_REQ;
        end else if (instr_ready) begin
          if (next_pc[1]) begin
            state_nxt = S_HALT;
            set_err   = 1'b1;
          end else begin
            pc_nxt    = next_pc;
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_HOLD);
  end

  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register has a defined reset value because the
  // outputs they drive are observable straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      discard        <= 1'b0;
      instr_code     <= NOP;
      instr_pc       <= RESET_PC;
      misaligned_err <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      discard <= discard_nxt;
      if (capture_pc)   instr_pc       <= pc;
      if (capture_code) instr_code     <= imem_rdata;
      if (set_err)      misaligned_err <= 1'b1;
    end
  end

endmodule
